// File: rtl/bnn_pkg.sv
// Shared sizing constants and types for the binarized fully-connected classifier stage.
package bnn_pkg;

    localparam int FC_N_IN  = 960;
    localparam int FC_N_OUT = 10;
    localparam int FC_CHUNK = 64;
    localparam int FC_NCH   = FC_N_IN / FC_CHUNK;
    localparam int FC_SW    = $clog2(FC_N_IN + 1) + 1;

    typedef logic signed [FC_SW-1:0] fc_score_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fc_state_e;

endpackage

// File: rtl/fc_bnn_popcount_chunk.sv
// Combinational popcount of one CHUNK-bit word, built as a balanced binary adder tree.
module popcount_chunk #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0]               bits,
    output logic [$clog2(CHUNK+1)-1:0]     count
);

    localparam int PW = $clog2(CHUNK + 1);

    // Heap layout: node i sums children 2i+1 and 2i+2; the last CHUNK nodes are the input bits.
    for (genvar i = 0; i < 2*CHUNK-1; i++) begin : g_node
        logic [PW-1:0] sum;
        if (i >= CHUNK-1) begin : g_leaf
            assign sum = PW'(bits[i-(CHUNK-1)]);
        end else begin : g_inner
            assign sum = g_node[2*i+1].sum + g_node[2*i+2].sum;
        end
    end

    assign count = g_node[0].sum;

endmodule

// File: rtl/fc_bnn.sv
// XNOR-popcount fully-connected layer with streamed weights and signed per-neuron scores.
// Define FC_ARGMAX_EN to build the running argmax; otherwise o_class is tied to zero.
module fc_bnn
    import bnn_pkg::*;
#(
    parameter int N_IN  = FC_N_IN,
    parameter int N_OUT = FC_N_OUT,
    parameter int CHUNK = FC_CHUNK
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    i_valid,
    output logic                                    o_ready,
    input  logic [0:N_IN-1]                         fmaps_in,
    output logic                                    o_w_en,
    output logic [$clog2(N_OUT*N_IN/CHUNK)-1:0]     o_w_addr,
    input  logic [0:CHUNK-1]                        i_w_data,
    output logic                                    o_valid,
    output logic [N_OUT*($clog2(N_IN+1)+1)-1:0]     o_scores,
    output logic [$clog2(N_OUT)-1:0]                o_class
);

    localparam int NCH   = N_IN / CHUNK;
    localparam int SW    = $clog2(N_IN + 1) + 1;
    localparam int ACC_W = SW - 1;
    localparam int PW    = $clog2(CHUNK + 1);
    localparam int AW    = $clog2(N_OUT * NCH);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    // 2*acc - N_IN is always representable in SW bits, so no clamp is needed.
    function automatic logic signed [SW-1:0] to_score(input logic [ACC_W-1:0] acc);
        logic signed [ACC_W+1:0] t;
        t = $signed({1'b0, acc, 1'b0}) - $signed((ACC_W+2)'(N_IN));
        return t[SW-1:0];
    endfunction

    fc_state_e state_q, state_d;

    logic [CW-1:0]   c_q;
    logic [NW-1:0]   n_q;
    logic [AW-1:0]   addr_q;
    logic [0:N_IN-1] frame_q;
    logic            accept;
    logic            last_issue;

    assign accept     = (state_q == IDLE) && i_valid;
    assign last_issue = (n_q == NW'(N_OUT-1)) && (c_q == CW'(NCH-1));

    assign o_ready  = (state_q == IDLE);
    assign o_w_en   = (state_q == RUN);
    assign o_w_addr = addr_q;
    assign o_valid  = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // p0: address issue, one weight word per cycle in neuron-major order
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q    <= '0;
            n_q    <= '0;
            addr_q <= '0;
        end else if (accept) begin
            c_q    <= '0;
            n_q    <= '0;
            addr_q <= '0;
        end else if (state_q == RUN) begin
            if (last_issue) begin
                c_q    <= '0;
                n_q    <= '0;
                addr_q <= '0;
            end else begin
                addr_q <= addr_q + 1'b1;
                if (c_q == CW'(NCH-1)) begin
                    c_q <= '0;
                    n_q <= n_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) frame_q <= fmaps_in;
    end

    // p1: weight word returns; XNOR against the matching frame slice and accumulate
    logic            vld_p1;
    logic [CW-1:0]   c_p1;
    logic [NW-1:0]   n_p1;
    logic            last_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= o_w_en;
    end

    always_ff @(posedge clk) begin
        c_p1 <= c_q;
        n_p1 <= n_q;
    end

    assign last_p1 = (c_p1 == CW'(NCH-1));

    logic [CHUNK-1:0]        xnor_bits;
    logic [PW-1:0]           pop_cnt;
    logic [ACC_W-1:0]        acc_q;
    logic [ACC_W-1:0]        acc_sum;
    logic signed [SW-1:0]    score_new;
    logic signed [SW-1:0]    score_w [N_OUT];

    assign xnor_bits = ~(frame_q[int'(c_p1)*CHUNK +: CHUNK] ^ i_w_data);

    popcount_chunk #(.CHUNK(CHUNK)) u_popcount (
        .bits  (xnor_bits),
        .count (pop_cnt)
    );

    assign acc_sum   = acc_q + ACC_W'(pop_cnt);
    assign score_new = to_score(acc_sum);

    always_ff @(posedge clk) begin
        if (accept)      acc_q <= '0;
        else if (vld_p1) acc_q <= last_p1 ? '0 : acc_sum;
    end

    always_ff @(posedge clk) begin
        if (vld_p1 && last_p1) score_w[n_p1] <= score_new;
    end

    // The last neuron finalizes during DRAIN, so it is taken straight from the adder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_scores <= '0;
        end else if (state_q == DRAIN) begin
            for (int n = 0; n < N_OUT; n++)
                o_scores[n*SW +: SW] <= (n == N_OUT-1) ? score_new : score_w[n];
        end
    end

`ifdef FC_ARGMAX_EN
    logic signed [SW-1:0] best_score_q;
    logic [NW-1:0]        best_idx_q;
    logic                 take_new;
    logic [NW-1:0]        best_idx_d;

    // Strictly greater keeps the lowest index on ties; neuron 0 seeds the search.
    assign take_new   = (n_p1 == '0) || (score_new > best_score_q);
    assign best_idx_d = take_new ? n_p1 : best_idx_q;

    always_ff @(posedge clk) begin
        if (vld_p1 && last_p1 && take_new) begin
            best_score_q <= score_new;
            best_idx_q   <= n_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                 o_class <= '0;
        else if (state_q == DRAIN)  o_class <= best_idx_d;
    end
`else
    assign o_class = '0;
`endif

endmodule

// File: tb/tb_fc_bnn.sv
// Directed bench for fc_bnn with a one-cycle-latency weight memory model.
module tb_fc_bnn;
    import bnn_pkg::*;

    localparam int N_IN  = FC_N_IN;
    localparam int N_OUT = FC_N_OUT;
    localparam int CHUNK = FC_CHUNK;
    localparam int NCH   = FC_NCH;
    localparam int SW    = FC_SW;
    localparam int AW    = $clog2(N_OUT*NCH);
    localparam int CLW   = $clog2(N_OUT);
    localparam int LAT   = N_OUT*NCH + 2;
`ifdef FC_ARGMAX_EN
    localparam bit ARGMAX_ON = 1'b1;
`else
    localparam bit ARGMAX_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   i_valid = 1'b0;
    logic [0:N_IN-1]        fmaps_in = '0;
    logic [0:CHUNK-1]       i_w_data = '0;
    logic                   o_ready;
    logic                   o_w_en;
    logic [AW-1:0]          o_w_addr;
    logic                   o_valid;
    logic [N_OUT*SW-1:0]    o_scores;
    logic [CLW-1:0]         o_class;

    logic [0:CHUNK-1]       wmem [N_OUT*NCH];
    int                     m_tab [N_OUT];
    logic [N_OUT*SW-1:0]    exp_scores;
    int                     cyc = 0;
    int                     n_chk = 0;
    int                     n_fail = 0;

    fc_bnn dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .fmaps_in (fmaps_in),
        .o_w_en   (o_w_en),
        .o_w_addr (o_w_addr),
        .i_w_data (i_w_data),
        .o_valid  (o_valid),
        .o_scores (o_scores),
        .o_class  (o_class)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (o_w_en) i_w_data <= wmem[o_w_addr];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:N_IN-1] rand_frame();
        logic [0:N_IN-1] r;
        for (int i = 0; i < N_IN/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Neuron n's weights agree with f on its first m_tab[n] bits and disagree on the rest.
    task automatic load_weights(input logic [0:N_IN-1] f);
        logic b;
        for (int n = 0; n < N_OUT; n++) begin
            for (int i = 0; i < N_IN; i++) begin
                b = (i < m_tab[n]) ? f[i] : ~f[i];
                wmem[n*NCH + i/CHUNK][i%CHUNK] = b;
            end
            exp_scores[n*SW +: SW] = SW'(2*m_tab[n] - N_IN);
        end
    endtask

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (o_ready) ok = 1'b1;
        end
        check({name, "_ready_wait"}, 128'(ok), 128'(1));
    endtask

    task automatic run_frame(input string name, input logic [0:N_IN-1] f, input int cls);
        int t0, tv, wen_n, addr_err;
        bit seen;
        load_weights(f);
        wait_ready(name);
        @(posedge clk); #1;
        fmaps_in = f;
        i_valid  = 1'b1;
        @(posedge clk); #1;
        t0       = cyc;
        i_valid  = 1'b0;
        fmaps_in = ~f;
        check({name, "_busy"}, 128'(o_ready), 128'(0));
        seen = 1'b0; tv = 0; wen_n = 0; addr_err = 0;
        for (int k = 0; k < LAT + 20 && !seen; k++) begin
            @(negedge clk);
            if (o_w_en) begin
                if (int'(o_w_addr) != wen_n) addr_err++;
                wen_n++;
            end
            if (o_valid) begin
                seen = 1'b1;
                tv   = cyc + 1;
            end
        end
        check({name, "_valid_seen"}, 128'(seen), 128'(1));
        check({name, "_latency"}, 128'(tv - t0), 128'(LAT));
        check({name, "_wen_count"}, 128'(wen_n), 128'(N_OUT*NCH));
        check({name, "_addr_seq_err"}, 128'(addr_err), 128'(0));
        check({name, "_scores"}, 128'(o_scores), 128'(exp_scores));
        check({name, "_class"}, 128'(o_class), 128'(ARGMAX_ON ? cls : 0));
        @(negedge clk);
        check({name, "_pulse_end"}, 128'(o_valid), 128'(0));
        check({name, "_ready_after"}, 128'(o_ready), 128'(1));
        check({name, "_hold"}, 128'(o_scores), 128'(exp_scores));
    endtask

    task automatic wait_valid_and_check(input string name, input int cls);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < LAT + 20 && !seen; k++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        check({name, "_valid_seen"}, 128'(seen), 128'(1));
        check({name, "_scores"}, 128'(o_scores), 128'(exp_scores));
        check({name, "_class"}, 128'(o_class), 128'(ARGMAX_ON ? cls : 0));
        @(negedge clk);
    endtask

    task automatic continuous_valid(input logic [0:N_IN-1] f0, input int cls);
        int acc_t [4];
        int acc_n, rdy_n, vld_n;
        acc_n = 0; rdy_n = 0; vld_n = 0;
        load_weights(f0);
        wait_ready("cont");
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            fmaps_in = o_ready ? f0 : rand_frame();
            i_valid  = 1'b1;
            @(negedge clk);
            if (o_ready) begin
                rdy_n++;
                if (acc_n < 4) acc_t[acc_n] = cyc + 1;
                acc_n++;
            end
            if (o_valid) begin
                vld_n++;
                check("cont_scores_1", 128'(o_scores), 128'(exp_scores));
            end
        end
        check("cont_accepts", 128'(acc_n), 128'(2));
        check("cont_accept_gap", 128'((acc_n >= 2) ? acc_t[1] - acc_t[0] : 0), 128'(LAT + 1));
        check("cont_ready_cycles", 128'(rdy_n), 128'(2));
        check("cont_valid_pulses", 128'(vld_n), 128'(1));
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_valid_and_check("cont_2", cls);
    endtask

    task automatic reset_mid_run(input logic [0:N_IN-1] f);
        int vld_n;
        load_weights(f);
        wait_ready("rst");
        @(posedge clk); #1;
        fmaps_in = f;
        i_valid  = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (49) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 128'(o_ready), 128'(1));
        check("rst_wen", 128'(o_w_en), 128'(0));
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_scores", 128'(o_scores), 128'(0));
        check("rst_class", 128'(o_class), 128'(0));
        vld_n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_valid) vld_n++;
        end
        check("rst_no_valid", 128'(vld_n), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [0:N_IN-1] fa;
        logic [0:N_IN-1] fb;
        fa = rand_frame();
        fb = rand_frame();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 128'(o_ready), 128'(1));
        check("reset_valid", 128'(o_valid), 128'(0));
        check("reset_wen", 128'(o_w_en), 128'(0));
        check("reset_waddr", 128'(o_w_addr), 128'(0));
        check("reset_scores", 128'(o_scores), 128'(0));
        check("reset_class", 128'(o_class), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        m_tab = '{960, 960, 960, 960, 960, 960, 960, 960, 960, 960};
        run_frame("all_match", '1, 0);

        m_tab = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("all_miss", '1, 0);

        m_tab = '{0, 0, 0, 0, 0, 0, 0, 960, 0, 0};
        run_frame("neuron7", fa, 7);

        m_tab = '{0, 0, 0, 500, 0, 0, 0, 0, 0, 0};
        run_frame("neuron3_500", fa, 3);

        m_tab = '{0, 96, 192, 288, 384, 480, 576, 672, 768, 864};
        run_frame("ramp", fb, 9);

        m_tab = '{10, 500, 700, 3, 700, 0, 0, 0, 0, 0};
        run_frame("tie", fb, 2);

        m_tab = '{5, 900, 17, 900, 4, 0, 960, 33, 959, 1};
        continuous_valid(fa, 6);

        m_tab = '{0, 0, 0, 500, 0, 0, 0, 0, 0, 0};
        reset_mid_run(fb);
        run_frame("after_reset", fb, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
